screentext_writer: RTL and testbench
====================================

Name: screentext_writer

Overview:
- Formats game status (velocity, angle, target X/Y, fire flag, PS/2 text line) into ASCII and writes it into an internal dual-port character RAM at fixed screen offsets.
- The VGA character renderer reads the RAM through a registered read port.
- A sequencer FSM snapshots the inputs, converts binary to decimal with a serial shift-add-3 converter, and writes one character per cycle.
- Refresh is event-triggered and coalesced.

Parameters:
- ADDR_W, 8, character RAM address width; depth = 2**ADDR_W.
- LINE_CHARS, 32, characters in the PS/2 text line; ps2_line_content width = 8*LINE_CHARS.
- COORD_DIGITS, 4, decimal digits shown per target coordinate.
- VEL_BASE, 0, RAM address of the first velocity digit.
- ANG_BASE, 8, address of the first angle digit.
- TX_BASE, 16, address of the first target-X digit.
- TY_BASE, 24, address of the first target-Y digit.
- FIRE_BASE, 31, address of the fire indicator.
- LINE_BASE, 64, address of the first PS/2 line character.

Ports:
- clock  in  1  system clock, all logic on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- velocity  in  8  unsigned velocity.
- angle  in  8  unsigned angle.
- targetx  in  32  unsigned target X.
- targety  in  32  unsigned target Y.
- fire  in  1  fire button level.
- ps2_line_content  in  8*LINE_CHARS  ASCII line; char i = bits [8i+7:8i], i=0 leftmost.
- ps2_line_ready  in  1  level; line valid/updated.
- rd_add  in  ADDR_W  renderer read address.
- rd_out  out  8  read data, 1-cycle latency.
- busy  out  1  refresh in progress.
- wr_en  out  1  RAM write strobe (observability).
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  8  RAM write data.

Behaviour:
- Reset values: busy=0, wr_en=0, wr_addr=0, wr_data=0, rd_out=0, FSM=IDLE, pending=0, snapshot registers=0. RAM contents are not reset except under the option below.
- Trigger: any of the following raises pending (one registered compare per cycle):
  - rising edge of fire;
  - rising edge of ps2_line_ready;
  - velocity, angle, targetx or targety differing from the last snapshot.
- Triggers during busy are coalesced into a single pending refresh, started the cycle after DONE.
- FSM states:
  - IDLE: pending=1 -> SNAP.
  - SNAP: register all inputs, clear pending, busy=1.
  - For each numeric field in the order VEL, ANG, TX, TY:
    - LOAD (1 cycle);
    - SHIFT (W cycles; W=8 for velocity/angle, 32 for targets);
    - EMIT (N digit writes, most-significant first at BASE..BASE+N-1; N=3 for velocity/angle, COORD_DIGITS for targets).
  - FIRE: 1 write at FIRE_BASE, 0x46 'F' if the snapshot fire=1, else 0x20.
  - LINE: LINE_CHARS writes at LINE_BASE+i; bytes outside 0x20..0x7E are written as 0x20.
  - DONE: busy=0 -> IDLE.
- Refresh duration, SNAP through the last LINE write: 1 + 12 + 12 + 2*(33+COORD_DIGITS) + 1 + LINE_CHARS cycles. With defaults this is 132.
- Digits are ASCII 0x30+d with leading zeros kept.
- Coordinates are clamped to 10**COORD_DIGITS-1 before conversion (saturating display).
- Addresses wrap modulo 2**ADDR_W.
- Read port:
  - rd_out registered, valid the cycle after rd_add.
  - A read and write to the same address in the same cycle returns the old data.
- Reset mid-refresh:
  - FSM returns to IDLE, busy=0 and pending=0 immediately.
  - Characters already written remain.
  - The snapshot clears to 0, so any nonzero input retriggers a refresh after reset.

Optional Feature:
- Macro SCREENTEXT_CLEAR_EN.
- Defined: after resetn deasserts, the FSM enters CLEAR and writes 0x20 to every address 0..2**ADDR_W-1 (one per cycle, busy=1) before servicing pending.
- Undefined: no CLEAR state; RAM is uninitialised until the first refresh.

Decomposition:
- Package screentext_pkg: FSM state enum; ASCII constants SPACE=0x20, ZERO=0x30, FIRE_CH=0x46; field-order encoding.
- Sub-module bin2bcd_serial:
  - Parameters: W input bits, N digits.
  - Interface: start/value in; done/bcd out; runs W cycles after start.

Test Plan:
- Reset then velocity=123, angle=45, targetx=7, targety=20000, fire=1 -> busy high 132 cycles; RAM holds "123" @0, "045" @8, "0007" @16, "9999" @24 (clamped), 'F' @31.
- ps2_line_content char0='H', char1=0x0D, rest 'A', pulse ps2_line_ready -> RAM[64]='H', RAM[65]=0x20, RAM[66..95]='A'.
- Change angle three times while busy -> exactly one additional refresh after DONE, showing the final angle.
- Assert resetn low at cycle 50 of a refresh -> busy=0 next cycle, wr_en never asserts again until a new trigger.
- Write RAM[16] and read rd_add=16 in the same cycle -> rd_out shows the old value, the new value on the next read.
- With SCREENTEXT_CLEAR_EN -> after reset, 256 consecutive space writes to addresses 0..255 precede the first field write.

Source files
------------

// File: rtl/screentext_pkg.sv
// Shared types and constants for the screen-text writer.
// SCREENTEXT_CLEAR_EN adds a post-reset RAM clear state.
package screentext_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
`ifdef SCREENTEXT_CLEAR_EN
    ST_CLEAR,
`endif
    ST_SNAP,
    ST_LOAD,
    ST_SHIFT,
    ST_EMIT,
    ST_FIRE,
    ST_LINE,
    ST_DONE
  } st_e;

  // Numeric fields are refreshed in this order.
  typedef enum logic [1:0] {FLD_VEL, FLD_ANG, FLD_TX, FLD_TY} fld_e;

  typedef struct packed {
    logic [7:0]  vel;
    logic [7:0]  ang;
    logic [31:0] tx;
    logic [31:0] ty;
    logic        fire;
  } snap_t;

  localparam logic [7:0] SPACE   = 8'h20;
  localparam logic [7:0] ZERO    = 8'h30;
  localparam logic [7:0] FIRE_CH = 8'h46;

  function automatic logic [7:0] printable(input logic [7:0] c);
    return (c >= 8'h20 && c <= 8'h7e) ? c : SPACE;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial shift-add-3 binary to BCD converter: W cycles after a start pulse.
// done is high during the final shift cycle, so bcd is valid on the next cycle.
module bin2bcd_serial
  import screentext_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 3
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [W-1:0]        value,
  output logic                done,
  output logic [N-1:0][3:0]   bcd
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]       sh;
  logic [CW-1:0]      left;
  logic [N-1:0][3:0]  adj;
  logic [4*N-1:0]     adj_f;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < N; i++)
      if (bcd[i] >= 4'd5) adj[i] = bcd[i] + 4'd3;
  end

  assign adj_f = adj;
  assign done  = (left == CW'(1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sh   <= '0;
      bcd  <= '0;
      left <= '0;
    end else if (start) begin
      sh   <= value;
      bcd  <= '0;
      left <= CW'(W);
    end else if (left != '0) begin
      bcd  <= {adj_f[4*N-2:0], sh[W-1]};
      sh   <= sh << 1;
      left <= left - 1'b1;
    end
  end

endmodule

// File: rtl/screentext_writer.sv
// Formats game status as ASCII into a dual-port character RAM for the renderer.
// Define SCREENTEXT_CLEAR_EN to blank the whole RAM after every reset.
module screentext_writer
  import screentext_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int LINE_CHARS   = 32,
  parameter int COORD_DIGITS = 4,
  parameter int VEL_BASE     = 0,
  parameter int ANG_BASE     = 8,
  parameter int TX_BASE      = 16,
  parameter int TY_BASE      = 24,
  parameter int FIRE_BASE    = 31,
  parameter int LINE_BASE    = 64
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [7:0]              velocity,
  input  logic [7:0]              angle,
  input  logic [31:0]             targetx,
  input  logic [31:0]             targety,
  input  logic                    fire,
  input  logic [8*LINE_CHARS-1:0] ps2_line_content,
  input  logic                    ps2_line_ready,
  input  logic [ADDR_W-1:0]       rd_add,
  output logic [7:0]              rd_out,
  output logic                    busy,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [7:0]              wr_data
);
  localparam int DEPTH   = 2**ADDR_W;
  localparam int CNT_MAX = (DEPTH > LINE_CHARS) ? DEPTH : LINE_CHARS;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int LW      = $clog2(LINE_CHARS);
  localparam logic [31:0] COORD_MAX = 32'(10**COORD_DIGITS - 1);

  st_e                         st, st_nx;
  fld_e                        fld, fld_nx;
  logic [CW-1:0]               cnt, cnt_nx;
  snap_t                       snap;
  logic [LINE_CHARS-1:0][7:0]  snap_line;
  logic                        fire_q, rdy_q, pending, trig;
  logic                        snap_en, conv_start, wide;
  logic                        we_nx;
  logic [ADDR_W-1:0]           wa_nx;
  logic [7:0]                  wd_nx;
  logic [7:0]                  v8;
  logic [31:0]                 t_raw, v32;
  logic                        done8, done32;
  logic [2:0][3:0]             bcd8;
  logic [COORD_DIGITS-1:0][3:0] bcd32;
  logic [3:0]                  dig;
  int                          base, ndig;
  logic [7:0]                  mem [DEPTH];
`ifdef SCREENTEXT_CLEAR_EN
  logic                        cleared;
`endif

  // Any change against the last snapshot, or a rising edge, requests a refresh.
  assign trig = (fire & ~fire_q) | (ps2_line_ready & ~rdy_q) |
                (velocity != snap.vel) | (angle != snap.ang) |
                (targetx != snap.tx) | (targety != snap.ty);

  assign wide  = (fld == FLD_TX) || (fld == FLD_TY);
  assign v8    = (fld == FLD_VEL) ? snap.vel : snap.ang;
  assign t_raw = (fld == FLD_TX) ? snap.tx : snap.ty;
  assign v32   = (t_raw > COORD_MAX) ? COORD_MAX : t_raw;

  bin2bcd_serial #(.W(8), .N(3)) u_conv8 (
    .clock(clock), .resetn(resetn), .start(conv_start & ~wide),
    .value(v8), .done(done8), .bcd(bcd8)
  );

  bin2bcd_serial #(.W(32), .N(COORD_DIGITS)) u_conv32 (
    .clock(clock), .resetn(resetn), .start(conv_start & wide),
    .value(v32), .done(done32), .bcd(bcd32)
  );

  // Most-significant digit is emitted first.
  always_comb begin
    dig = '0;
    if (wide) begin
      for (int i = 0; i < COORD_DIGITS; i++)
        if (cnt == CW'(COORD_DIGITS - 1 - i)) dig = bcd32[i];
    end else begin
      for (int i = 0; i < 3; i++)
        if (cnt == CW'(2 - i)) dig = bcd8[i];
    end
  end

  always_comb begin
    st_nx      = st;
    fld_nx     = fld;
    cnt_nx     = cnt;
    we_nx      = 1'b0;
    wa_nx      = wr_addr;
    wd_nx      = wr_data;
    snap_en    = 1'b0;
    conv_start = 1'b0;
    ndig       = wide ? COORD_DIGITS : 3;
    case (fld)
      FLD_VEL: base = VEL_BASE;
      FLD_ANG: base = ANG_BASE;
      FLD_TX:  base = TX_BASE;
      default: base = TY_BASE;
    endcase
    case (st)
      ST_IDLE: begin
`ifdef SCREENTEXT_CLEAR_EN
        if (!cleared) begin
          st_nx  = ST_CLEAR;
          cnt_nx = '0;
        end else
`endif
        if (pending) st_nx = ST_SNAP;
      end
`ifdef SCREENTEXT_CLEAR_EN
      ST_CLEAR: begin
        we_nx  = 1'b1;
        wa_nx  = cnt[ADDR_W-1:0];
        wd_nx  = SPACE;
        cnt_nx = cnt + 1'b1;
        if (cnt == CW'(DEPTH - 1)) begin
          cnt_nx = '0;
          st_nx  = ST_IDLE;
        end
      end
`endif
      ST_SNAP: begin
        snap_en = 1'b1;
        fld_nx  = FLD_VEL;
        cnt_nx  = '0;
        st_nx   = ST_LOAD;
      end
      ST_LOAD: begin
        conv_start = 1'b1;
        st_nx      = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (wide ? done32 : done8) begin
          cnt_nx = '0;
          st_nx  = ST_EMIT;
        end
      end
      ST_EMIT: begin
        we_nx  = 1'b1;
        wa_nx  = ADDR_W'(base + int'(cnt));
        wd_nx  = ZERO + {4'h0, dig};
        cnt_nx = cnt + 1'b1;
        if (cnt == CW'(ndig - 1)) begin
          cnt_nx = '0;
          if (fld == FLD_TY) st_nx = ST_FIRE;
          else begin
            fld_nx = fld_e'(fld + 2'd1);
            st_nx  = ST_LOAD;
          end
        end
      end
      ST_FIRE: begin
        we_nx  = 1'b1;
        wa_nx  = ADDR_W'(FIRE_BASE);
        wd_nx  = snap.fire ? FIRE_CH : SPACE;
        cnt_nx = '0;
        st_nx  = ST_LINE;
      end
      ST_LINE: begin
        we_nx  = 1'b1;
        wa_nx  = ADDR_W'(LINE_BASE + int'(cnt));
        wd_nx  = printable(snap_line[cnt[LW-1:0]]);
        cnt_nx = cnt + 1'b1;
        if (cnt == CW'(LINE_CHARS - 1)) begin
          cnt_nx = '0;
          st_nx  = ST_DONE;
        end
      end
      ST_DONE: st_nx = pending ? ST_SNAP : ST_IDLE;
      default: st_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st        <= ST_IDLE;
      fld       <= FLD_VEL;
      cnt       <= '0;
      pending   <= 1'b0;
      fire_q    <= 1'b0;
      rdy_q     <= 1'b0;
      snap      <= '0;
      snap_line <= '0;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      st      <= st_nx;
      fld     <= fld_nx;
      cnt     <= cnt_nx;
      fire_q  <= fire;
      rdy_q   <= ps2_line_ready;
      // Snapshot captures whatever raised the request, so SNAP clears it outright.
      pending <= (st == ST_SNAP) ? 1'b0 : (pending | trig);
      if (snap_en) begin
        snap      <= '{vel: velocity, ang: angle, tx: targetx, ty: targety, fire: fire};
        snap_line <= ps2_line_content;
      end
      busy    <= (st_nx != ST_IDLE) && (st_nx != ST_DONE);
      wr_en   <= we_nx;
      wr_addr <= wa_nx;
      wr_data <= wd_nx;
    end
  end

`ifdef SCREENTEXT_CLEAR_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cleared <= 1'b0;
    else if (st == ST_CLEAR && cnt == CW'(DEPTH - 1)) cleared <= 1'b1;
  end
`endif

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-before-write: a same-cycle collision returns the previous contents.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) rd_out <= '0;
    else         rd_out <= mem[rd_add];
  end

endmodule

// File: tb/tb_screentext_writer.sv
// Scoreboard bench for screentext_writer: expected RAM writes are queued as
// stimulus is applied and matched against the write strobe in order.
module tb_screentext_writer;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic [7:0]   velocity, angle;
  logic [31:0]  targetx, targety;
  logic         fire;
  logic [255:0] ps2_line_content;
  logic         ps2_line_ready;
  logic [7:0]   rd_add;
  logic [7:0]   rd_out;
  logic         busy, wr_en;
  logic [7:0]   wr_addr, wr_data;

  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t        exp_q[$];
  logic [7:0] shadow [256];
  int         n_chk = 0, n_pass = 0, n_rise = 0;
  logic       busy_q = 1'b0;

`ifdef SCREENTEXT_CLEAR_EN
  localparam int CLR_RISES = 1;
`else
  localparam int CLR_RISES = 0;
`endif

  screentext_writer dut (
    .clock(clock), .resetn(resetn), .velocity(velocity), .angle(angle),
    .targetx(targetx), .targety(targety), .fire(fire),
    .ps2_line_content(ps2_line_content), .ps2_line_ready(ps2_line_ready),
    .rd_add(rd_add), .rd_out(rd_out), .busy(busy), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clock = ~clock;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  task automatic push_wr(int a, int d);
    wr_t e;
    e.addr = 8'(a);
    e.data = 8'(d);
    exp_q.push_back(e);
  endtask

  task automatic push_num(int base, longint v, int n);
    longint p;
    for (int i = 0; i < n; i++) begin
      p = 1;
      for (int k = 0; k < n - 1 - i; k++) p = p * 10;
      push_wr(base + i, 'h30 + int'((v / p) % 10));
    end
  endtask

  task automatic push_refresh(int vel, int ang, longint tx, longint ty, bit f,
                              logic [255:0] line);
    logic [7:0] c;
    push_num(0, vel, 3);
    push_num(8, ang, 3);
    push_num(16, (tx > 9999) ? 9999 : tx, 4);
    push_num(24, (ty > 9999) ? 9999 : ty, 4);
    push_wr(31, f ? 'h46 : 'h20);
    for (int i = 0; i < 32; i++) begin
      c = line[8*i +: 8];
      push_wr(64 + i, (c >= 8'h20 && c <= 8'h7e) ? int'(c) : 'h20);
    end
  endtask

  task automatic wait_busy(logic lvl, int lim, string tag);
    int n = 0;
    while (busy !== lvl && n < lim) begin
      @(negedge clock);
      n++;
    end
    chk(tag, busy, lvl);
  endtask

  task automatic rd(int a, logic [7:0] want, string tag);
    @(negedge clock);
    rd_add = 8'(a);
    @(negedge clock);
    chk(tag, rd_out, want);
  endtask

  task automatic release_reset();
`ifdef SCREENTEXT_CLEAR_EN
    for (int a = 0; a < 256; a++) push_wr(a, 'h20);
`endif
    @(negedge clock);
    resetn = 1'b1;
`ifdef SCREENTEXT_CLEAR_EN
    wait_busy(1'b1, 10, "clr_start");
    wait_busy(1'b0, 400, "clr_end");
`endif
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clock) begin : mon
    wr_t e;
    if (busy && !busy_q) n_rise++;
    busy_q = busy;
    if (resetn && wr_en) begin
      chk("wr_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
        shadow[e.addr] = e.data;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, r0;
    velocity = '0; angle = '0; targetx = '0; targety = '0; fire = 1'b0;
    ps2_line_content = '0; ps2_line_ready = 1'b0; rd_add = '0;

    repeat (3) @(negedge clock);
    chk("rst_busy",    busy,    0);
    chk("rst_wr_en",   wr_en,   0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_out",  rd_out,  0);
    release_reset();

    // Refresh 1: numeric fields, clamp, fire indicator, blank line.
    @(negedge clock);
    velocity = 8'd123; angle = 8'd45; targetx = 32'd7; targety = 32'd20000; fire = 1'b1;
    push_refresh(velocity, angle, targetx, targety, fire, ps2_line_content);
    wait_busy(1'b1, 10, "r1_start");
    n = 0;
    while (busy && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("busy_len", n, 132);
    rd(0,  8'h31, "ram_vel0");
    rd(2,  8'h33, "ram_vel2");
    rd(8,  8'h30, "ram_ang0");
    rd(10, 8'h35, "ram_ang2");
    rd(19, 8'h37, "ram_tx3");
    rd(24, 8'h39, "ram_ty0");
    rd(27, 8'h39, "ram_ty3");
    rd(31, 8'h46, "ram_fire");

    // Refresh 2: line-ready edge, non-printable substitution.
    @(negedge clock);
    for (int i = 0; i < 32; i++) ps2_line_content[8*i +: 8] = 8'h41;
    ps2_line_content[7:0]  = 8'h48;
    ps2_line_content[15:8] = 8'h0d;
    ps2_line_ready = 1'b1;
    push_refresh(velocity, angle, targetx, targety, fire, ps2_line_content);
    wait_busy(1'b1, 10, "r2_start");
    @(negedge clock);
    ps2_line_ready = 1'b0;
    wait_busy(1'b0, 300, "r2_end");
    rd(64, 8'h48, "line0");
    rd(65, 8'h20, "line1_cr");
    rd(66, 8'h41, "line2");
    rd(95, 8'h41, "line31");

    // Refresh 3: same-cycle read/write collision on address 16.
    @(negedge clock);
    targetx = 32'd1234; fire = 1'b0;
    push_refresh(velocity, angle, targetx, targety, fire, ps2_line_content);
    n = 0;
    while (!(wr_en && wr_addr == 8'd16) && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("rw_hit", 32'(wr_en && wr_addr == 8'd16), 1);
    rd_add = 8'd16;
    @(negedge clock);
    chk("rd_old", rd_out, 8'h30);
    @(negedge clock);
    chk("rd_new", rd_out, 8'h31);
    wait_busy(1'b0, 300, "r3_end");
    rd(31, 8'h20, "ram_nofire");

    // Coalescing: three angle changes during one refresh yield one more.
    r0 = n_rise;
    @(negedge clock);
    angle = 8'd10;
    push_refresh(velocity, angle, targetx, targety, fire, ps2_line_content);
    wait_busy(1'b1, 10, "co_start");
    repeat (10) @(negedge clock);
    angle = 8'd11;
    repeat (10) @(negedge clock);
    angle = 8'd12;
    repeat (10) @(negedge clock);
    angle = 8'd13;
    push_refresh(velocity, angle, targetx, targety, fire, ps2_line_content);
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk("co_drain", exp_q.size(), 0);
    wait_busy(1'b0, 300, "co_end");
    repeat (20) @(negedge clock);
    chk("co_refreshes", n_rise - r0, 2);
    rd(8,  8'h30, "co_ang0");
    rd(9,  8'h31, "co_ang1");
    rd(10, 8'h33, "co_ang2");

    // Reset at cycle 50 of a refresh.
    @(negedge clock);
    velocity = 8'd200;
    push_refresh(velocity, angle, targetx, targety, fire, ps2_line_content);
    wait_busy(1'b1, 10, "mr_start");
    repeat (49) @(posedge clock);
    #1;
    resetn = 1'b0;
    velocity = '0; angle = '0; targetx = '0; targety = '0; fire = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk("mr_busy",  busy,  0);
    chk("mr_wr_en", wr_en, 0);
    r0 = n_rise;
    release_reset();
    repeat (300) @(negedge clock);
    chk("mr_no_retrig", n_rise - r0, CLR_RISES);
    chk("mr_queue", exp_q.size(), 0);
    rd(0, shadow[0], "mr_kept0");
    rd(5, shadow[5] === 8'hxx ? 8'h00 : shadow[5], "mr_kept5_dummy_skip") ;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
